// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: round-robin sharing of the frame-buffer write port between two
// pixel producers, with a full-frame clear sequencer and a saturating write counter.
module fb_write_scheduler #(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int XW = 8,
    parameter int YW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    input  logic [8:0]    clear_rgb,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [XW-1:0] a_x,
    input  logic [YW-1:0] a_y,
    input  logic [2:0]    a_r,
    input  logic [2:0]    a_g,
    input  logic [2:0]    a_b,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [XW-1:0] b_x,
    input  logic [YW-1:0] b_y,
    input  logic [2:0]    b_r,
    input  logic [2:0]    b_g,
    input  logic [2:0]    b_b,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [2:0]    wr_r,
    output logic [2:0]    wr_g,
    output logic [2:0]    wr_b,
    output logic          busy,
    output logic [23:0]   accept_count
);

    localparam logic [XW-1:0] X_LAST    = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(H - 1);
    localparam logic [23:0]   COUNT_MAX = 24'hFF_FFFF;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state, state_next;
    logic          last_grant_b;
    logic          grant_a, grant_b, a_fire, b_fire;
    logic          clear_start, clear_last;
    logic [XW-1:0] clear_x, next_x;
    logic [YW-1:0] clear_y, next_y;
    logic [8:0]    clear_color;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ARB;
        else       state <= state_next;
    end

    // clear_x/clear_y track the clear pixel currently shown on the write port
    always_comb begin
        grant_a     = a_valid & (~b_valid | last_grant_b);
        grant_b     = b_valid & (~a_valid | ~last_grant_b);
        a_ready     = (state == ARB) & ~clear_req & grant_a;
        b_ready     = (state == ARB) & ~clear_req & grant_b;
        a_fire      = a_valid & a_ready;
        b_fire      = b_valid & b_ready;
        clear_start = (state == ARB) & clear_req;
        clear_last  = (clear_x == X_LAST) & (clear_y == Y_LAST);
        next_x      = clear_x + XW'(1);
        next_y      = clear_y;
        if (clear_x == X_LAST) begin
            next_x = '0;
            next_y = clear_y + YW'(1);
        end
        state_next = state;
        case (state)
            ARB:     if (clear_start) state_next = CLEAR;
            CLEAR:   if (clear_last)  state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en        <= 1'b0;
            wr_x         <= '0;
            wr_y         <= '0;
            wr_r         <= '0;
            wr_g         <= '0;
            wr_b         <= '0;
            busy         <= 1'b0;
            accept_count <= '0;
            last_grant_b <= 1'b1;
            clear_x      <= '0;
            clear_y      <= '0;
            clear_color  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear_start) begin
                clear_x              <= '0;
                clear_y              <= '0;
                clear_color          <= clear_rgb;
                wr_en                <= 1'b1;
                wr_x                 <= '0;
                wr_y                 <= '0;
                {wr_r, wr_g, wr_b}   <= clear_rgb;
                busy                 <= 1'b1;
            end else if (state == CLEAR) begin
                if (clear_last) begin
                    busy <= 1'b0;
                end else begin
                    clear_x            <= next_x;
                    clear_y            <= next_y;
                    wr_en              <= 1'b1;
                    wr_x               <= next_x;
                    wr_y               <= next_y;
                    {wr_r, wr_g, wr_b} <= clear_color;
                end
            end else if (a_fire | b_fire) begin
                wr_en        <= 1'b1;
                last_grant_b <= b_fire;
                if (a_fire) begin
                    wr_x <= a_x;
                    wr_y <= a_y;
                    wr_r <= a_r;
                    wr_g <= a_g;
                    wr_b <= a_b;
                end else begin
                    wr_x <= b_x;
                    wr_y <= b_y;
                    wr_r <= b_r;
                    wr_g <= b_g;
                    wr_b <= b_b;
                end
                if (accept_count != COUNT_MAX) accept_count <= accept_count + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed and randomized stimulus against a queue-based
// reference model of the write scheduler, using a small 4x3 frame.
module tb_fb_write_scheduler;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int XW = 8;
    localparam int YW = 8;
    localparam int unsigned COUNT_MAX = 32'h00FF_FFFF;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear_req;
    logic [8:0]    clear_rgb;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [XW-1:0] a_x, b_x, wr_x;
    logic [YW-1:0] a_y, b_y, wr_y;
    logic [2:0]    a_r, a_g, a_b, b_r, b_g, b_b;
    logic [2:0]    wr_r, wr_g, wr_b;
    logic          wr_en, busy;
    logic [23:0]   accept_count;

    fb_write_scheduler #(.W(W), .H(H), .XW(XW), .YW(YW)) dut (
        .clock(clock), .reset(reset),
        .clear_req(clear_req), .clear_rgb(clear_rgb),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y),
        .a_r(a_r), .a_g(a_g), .a_b(a_b),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y),
        .b_r(b_r), .b_g(b_g), .b_b(b_b),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .busy(busy), .accept_count(accept_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int rgb;
    } pix_t;

    // Reference model: pending clear pixels as a queue, plus the expected registered outputs
    pix_t        clear_q[$];
    bit          m_last_b;
    int unsigned m_count;
    bit          exp_wr_en, exp_busy;
    int          exp_x, exp_y, exp_rgb;
    bit          fired_a, fired_b;
    int          checks = 0;
    int          passes = 0;
    int          clear_writes, busy_cycles;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    endtask

    task automatic applyStimulus(input bit av, input bit bv, input bit cr, input logic [8:0] crgb);
        a_valid   = av;
        b_valid   = bv;
        clear_req = cr;
        clear_rgb = crgb;
    endtask

    task automatic randomA();
        a_x = XW'($urandom);
        a_y = YW'($urandom);
        {a_r, a_g, a_b} = 9'($urandom);
    endtask

    task automatic randomB();
        b_x = XW'($urandom);
        b_y = YW'($urandom);
        {b_r, b_g, b_b} = 9'($urandom);
    endtask

    task automatic modelReset();
        clear_q.delete();
        m_last_b  = 1'b1;
        m_count   = 0;
        exp_wr_en = 1'b0;
        exp_busy  = 1'b0;
        exp_x     = 0;
        exp_y     = 0;
        exp_rgb   = 0;
    endtask

    function automatic bit expReady(input bit for_a);
        bit win_a, win_b;
        win_a = a_valid && (!b_valid || m_last_b);
        win_b = b_valid && (!a_valid || !m_last_b);
        return !exp_busy && !clear_req && (for_a ? win_a : win_b);
    endfunction

    // One clock: check readies before the edge, advance the model at the edge, check outputs after
    task automatic step();
        bit   ea, eb;
        pix_t p;
        #1;
        ea = expReady(1'b1);
        eb = expReady(1'b0);
        checkOutput("a_ready", 32'(a_ready), 32'(ea));
        checkOutput("b_ready", 32'(b_ready), 32'(eb));
        @(posedge clock);
        if (!exp_busy && clear_req)
            for (int i = 0; i < W * H; i++)
                clear_q.push_back('{x: i % W, y: i / W, rgb: int'(clear_rgb)});
        if (clear_q.size() > 0) begin
            p         = clear_q.pop_front();
            exp_wr_en = 1'b1;
            exp_busy  = 1'b1;
            exp_x     = p.x;
            exp_y     = p.y;
            exp_rgb   = p.rgb;
        end else begin
            exp_busy  = 1'b0;
            exp_wr_en = ea || eb;
            if (ea) begin
                exp_x   = int'(a_x);
                exp_y   = int'(a_y);
                exp_rgb = int'({a_r, a_g, a_b});
            end else if (eb) begin
                exp_x   = int'(b_x);
                exp_y   = int'(b_y);
                exp_rgb = int'({b_r, b_g, b_b});
            end
            if (ea || eb) begin
                m_last_b = eb;
                if (m_count < COUNT_MAX) m_count++;
            end
        end
        fired_a = ea;
        fired_b = eb;
        @(negedge clock);
        checkOutput("wr_en", 32'(wr_en), 32'(exp_wr_en));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("accept_count", 32'(accept_count), m_count);
        checkOutput("wr_x", 32'(wr_x), 32'(exp_x));
        checkOutput("wr_y", 32'(wr_y), 32'(exp_y));
        checkOutput("wr_rgb", 32'({wr_r, wr_g, wr_b}), 32'(exp_rgb));
        if (wr_en && busy) clear_writes++;
        if (busy) busy_cycles++;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_count"}, 32'(accept_count), 32'd0);
        checkOutput({tag, "_wr_xy"}, 32'({wr_x, wr_y}), 32'd0);
        checkOutput({tag, "_wr_rgb"}, 32'({wr_r, wr_g, wr_b}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        randomA();
        randomB();
        modelReset();
        fired_a = 1'b0;
        fired_b = 1'b0;
        repeat (2) @(negedge clock);
        checkAllZero("reset");
        reset = 1'b0;
        step();

        // Single requester A with a fixed pixel
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        a_x = 8'd5;
        a_y = 8'd7;
        {a_r, a_g, a_b} = {3'd3, 3'd1, 3'd6};
        step();
        checkOutput("single_pixel", 32'({wr_en, wr_x, wr_y, wr_r, wr_g, wr_b}),
                    32'({1'b1, 8'd5, 8'd7, 3'd3, 3'd1, 3'd6}));
        checkOutput("single_count", 32'(accept_count), 32'd1);

        // Both valid for six cycles: grants must alternate
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);
        randomA();
        randomB();
        for (int i = 0; i < 6; i++) begin
            step();
            if (fired_a) randomA();
            if (fired_b) randomB();
        end
        checkOutput("contention_count", 32'(accept_count), 32'd7);

        // Clear coinciding with a pending A request, plus an ignored mid-clear request
        randomA();
        applyStimulus(1'b1, 1'b0, 1'b1, 9'h1FF);
        clear_writes = 0;
        busy_cycles  = 0;
        step();
        for (int i = 0; i < W * H + 3; i++) begin
            clear_req = (i == 5);
            if (fired_a) a_valid = 1'b0;
            step();
        end
        checkOutput("clear_writes", 32'(clear_writes), 32'(W * H));
        checkOutput("clear_busy_cycles", 32'(busy_cycles), 32'(W * H));
        checkOutput("post_clear_count", 32'(accept_count), 32'd8);

        // Randomized traffic with occasional clears
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || fired_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                randomA();
            end
            if (!b_valid || fired_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                randomB();
            end
            clear_req = ($urandom_range(0, 59) == 0);
            clear_rgb = 9'($urandom);
            step();
        end

        // Saturation of the accepted-write counter
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        for (int i = 0; i < W * H + 2; i++) step();
        force dut.accept_count = 24'hFF_FFFC;
        #1;
        release dut.accept_count;
        m_count = 32'h00FF_FFFC;
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        for (int i = 0; i < 6; i++) begin
            randomA();
            step();
        end
        checkOutput("saturated_count", 32'(accept_count), 32'h00FF_FFFF);

        // Reset asserted mid-clear aborts it for good
        applyStimulus(1'b0, 1'b0, 1'b1, 9'h0AA);
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("abort");
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        clear_writes = 0;
        for (int i = 0; i < W * H + 4; i++) step();
        checkOutput("abort_no_writes", 32'(clear_writes), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Shares the VGA frame-buffer write port (x, y, 3-bit R/G/B) between two pixel producers, such as the adaptive-threshold engine and a secondary overlay source. It uses round-robin arbitration and a built-in full-screen clear sequencer. The block sits between the producers and `VGA_Ctrl`'s `write_*` inputs. It also exports a saturating accepted-write counter sized for `display_7seg`.

## Interface
- `W`, default 160: frame width in pixels.
- `H`, default 120: frame height in pixels.
- `XW`, default 8: x coordinate width. Requires W ≤ 2^XW.
- `YW`, default 8: y coordinate width. Requires H ≤ 2^YW.

Ports:
- `clock`  in  1  single clock (40 MHz pixel domain).
- `reset`  in  1  asynchronous, active-high reset.
- `clear_req`  in  1  single-cycle pulse that starts a full-frame clear.
- `clear_rgb`  in  9  clear colour {r,g,b}, captured on the cycle `clear_req` is accepted.
- `a_valid`, `b_valid`  in  1  requester write request.
- `a_ready`, `b_ready`  out  1  grant; a transfer occurs when valid & ready.
- `a_x`/`b_x`  in  XW; `a_y`/`b_y`  in  YW; `a_r,a_g,a_b`/`b_r,b_g,b_b`  in  3 each: request pixel.
- `wr_en`  out  1  frame-buffer write strobe.
- `wr_x`  out  XW; `wr_y`  out  YW; `wr_r`, `wr_g`, `wr_b`  out  3 each: registered write data.
- `busy`  out  1  high while clearing.
- `accept_count`  out  24  number of accepted requester writes; saturates at 0xFFFFFF.

## Operation
States:
- ARB: the arbiter is serving requests.
- CLEAR: the clear sequencer owns the write port.

Arbitration in ARB:
- Ready is combinational: `x_ready = (state==ARB) & ~clear_req & grant_x`.
- Only one valid requester: that requester is granted.
- Both valid: grant the one not granted most recently. `last_grant` resets to B, so A wins the first contention.
- `last_grant` updates only on an actual transfer.
- Holding valid with no grant is legal. Requesters must keep their data stable until the transfer.

Transfers:
- A transfer registers x, y, r, g and b into `wr_*` and drives `wr_en=1` on the next cycle.
- A cycle with no transfer (and not in CLEAR) gives `wr_en=0` next cycle. `wr_*` data holds its last value.
- Each transfer increments `accept_count` by 1. The count saturates at 0xFFFFFF and is cleared only by reset.

Clear sequencing:
- `clear_req` in ARB has priority over all requests. In that cycle both readies are 0, `clear_rgb` is latched, and the state moves to CLEAR.
- In CLEAR, the block emits one write per cycle in row-major order: (0,0), (1,0) … (W-1,0), (0,1) … (W-1,H-1). Each write uses the latched colour.
- Exactly W·H writes are issued. After (W-1,H-1) the state returns to ARB.
- `clear_req` received during CLEAR is ignored: no restart and no queuing.
- Both readies are 0 throughout CLEAR. Clear writes do not change `accept_count` or `last_grant`.

Reset:
- Asynchronous reset forces state=ARB, `wr_en=0`, `wr_x=0`, `wr_y=0`, `wr_r=wr_g=wr_b=0`, `busy=0`, `accept_count=0`, `last_grant=B`, and zeroes the clear counters.
- A reset asserted mid-clear aborts the clear immediately. The clear does not resume after reset.

## Timing
- Requester latency: a transfer in cycle N gives `wr_en=1` with the request's data in cycle N+1. Throughput is 1 write per cycle.
- Clear latency: `clear_req` in cycle N gives `busy=1` and the first clear write (0,0) in cycle N+1. The last write (W-1,H-1) is in cycle N+W·H.
- `busy` falls and readies may assert in cycle N+W·H+1, with `wr_en` reflecting that cycle's arbitration one cycle later.
- `busy` is registered and high exactly on the W·H clear-write cycles.
- Arbitration has no dead cycles: with both requesters continuously valid, grants alternate A, B, A, B every cycle.
- The x counter wraps to 0 and y increments on the same edge.

## Test plan
- **Reset values:** assert reset mid-operation → all outputs 0 asynchronously; after release, `a_ready` follows `a_valid` alone.
- **Single requester:** A sends (5,7,r=3,g=1,b=6) → `a_ready=1` in the same cycle; the next cycle shows `wr_en=1`, `wr_x=5`, `wr_y=7`, rgb 3/1/6; `accept_count=1`.
- **Contention:** A and B valid for 6 cycles → grant order A, B, A, B, A, B; 6 consecutive `wr_en` cycles; `accept_count=6`.
- **Clear with W=4, H=3:** `clear_req` with `clear_rgb=0x1FF` → 12 writes (0,0)…(3,2), all rgb 7/7/7; `busy` high for 12 cycles; pending A gets ready only afterwards; a second `clear_req` mid-clear is ignored.
- **Simultaneous events:** `clear_req` in the same cycle as `a_valid` → `a_ready=0`, clear runs, A transfers on the first ARB cycle.
- **Saturation and abort:** preload near 0xFFFFFF by forcing or a long run → the count holds at 0xFFFFFF; reset during clear → `busy=0`, no further clear writes.
